// File: rtl/udsp2_if.sv
// udsp2 memory-side bus: instruction fetch port, two data read ports and
// the data write port. The core connects through the master modport and
// the memory system through the slave modport.
interface udsp2_if #(
    parameter int IAW  = 9,
    parameter int DAW  = 10,
    parameter int DWW  = 36,
    parameter int NACC = 4
);
    localparam int ACW = (NACC > 1) ? $clog2(NACC) : 1;
    localparam int IWW = 6 + ACW + 3 * DAW;

    logic [IAW-1:0] addrI;
    logic [IWW-1:0] dataI;
    logic [DAW-1:0] addrA;
    logic [DAW-1:0] addrB;
    logic [DWW-1:0] dataA;
    logic [DWW-1:0] dataB;
    logic [DAW-1:0] addrW;
    logic [DWW-1:0] dataW;
    logic           writeEn;

    modport master (
        output addrI, addrA, addrB, addrW, dataW, writeEn,
        input  dataI, dataA, dataB
    );

    modport slave (
        input  addrI, addrA, addrB, addrW, dataW, writeEn,
        output dataI, dataA, dataB
    );
endinterface

// File: rtl/udsp2.sv
// udsp2: four-stage (FETCH, READ, EXECUTE, WRITEBACK) multiply/accumulate
// core with NACC double-width accumulator banks and one-deep operand
// forwarding from WRITEBACK into EXECUTE.
// Optional feature: define UDSP2_SAT_EN to saturate MulAcc/MulSub results
// to the signed 2*DWW limits; otherwise they wrap.
module udsp2 #(
    parameter int IAW  = 9,
    parameter int DAW  = 10,
    parameter int DWW  = 36,
    parameter int NACC = 4
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    start,
    output logic    running,
    output logic    done,
    udsp2_if.master bus
);
    localparam int ACW = (NACC > 1) ? $clog2(NACC) : 1;
    localparam int IWW = 6 + ACW + 3 * DAW;
    localparam int PW  = 2 * DWW;

    typedef enum logic [5:0] {
        OP_NOP    = 6'd0,
        OP_MUL    = 6'd1,
        OP_MULACC = 6'd2,
        OP_MULTOW = 6'd3,
        OP_ATOHI  = 6'd4,
        OP_ATOLO  = 6'd5,
        OP_HITOW  = 6'd6,
        OP_LOTOW  = 6'd7,
        OP_ATOW   = 6'd8,
        OP_MULSUB = 6'd9,
        OP_CLRACC = 6'd10,
        OP_HALT   = 6'd11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_e;

    state_e state, state_nx;

    logic [IAW-1:0]        pc;
    logic                  rd_valid;   // word arriving on dataI was fetched while running
    logic [IWW-1:0]        ex_ir;
    logic signed [PW-1:0]  bank [NACC];

    logic [5:0]            ex_op;
    logic [ACW-1:0]        ex_acc;
    logic [DAW-1:0]        ex_rw, ex_ra, ex_rb;
    logic                  halt_ex;
    logic                  bank_ok;

    logic signed [DWW-1:0] op_a, op_b;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  cur;
    logic signed [PW-1:0]  acc_res;
    logic                  is_sub;

    logic                  wr_en_nx;
    logic [DWW-1:0]        wr_data_nx;
    logic                  bank_we;
    logic signed [PW-1:0]  bank_nx;

    assign ex_op   = ex_ir[IWW-1 -: 6];
    assign ex_acc  = ex_ir[3*DAW +: ACW];
    assign ex_rw   = ex_ir[2*DAW +: DAW];
    assign ex_ra   = ex_ir[DAW +: DAW];
    assign ex_rb   = ex_ir[0 +: DAW];
    assign halt_ex = (ex_op == OP_HALT);
    assign bank_ok = (int'(ex_acc) < NACC);
    assign is_sub  = (ex_op == OP_MULSUB);

    assign bus.addrI = pc;
    assign bus.addrA = bus.dataI[DAW +: DAW];
    assign bus.addrB = bus.dataI[0 +: DAW];

    // Run-control state register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Run-control next state and status outputs; start overrides Halt
    always_comb begin
        state_nx = state;
        running  = (state == S_RUN);
        done     = (state == S_HALT);
        if (start)
            state_nx = S_RUN;
        else if (state == S_RUN && halt_ex)
            state_nx = S_HALT;
    end

    // Operand selection with WRITEBACK forwarding, product and bank read
    always_comb begin
        op_a = (bus.writeEn && bus.addrW == ex_ra) ? bus.dataW : bus.dataA;
        op_b = (bus.writeEn && bus.addrW == ex_rb) ? bus.dataW : bus.dataB;
        prod = PW'(op_a) * PW'(op_b);
        cur  = bank_ok ? bank[ex_acc] : '0;
    end

`ifdef UDSP2_SAT_EN
    logic [PW:0] acc_wide;

    // Accumulate with clamping to the signed double-width limits
    always_comb begin
        if (is_sub) acc_wide = {cur[PW-1], cur} - {prod[PW-1], prod};
        else        acc_wide = {cur[PW-1], cur} + {prod[PW-1], prod};
        if (acc_wide[PW] != acc_wide[PW-1])
            acc_res = acc_wide[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
        else
            acc_res = acc_wide[PW-1:0];
    end
`else
    // Accumulate modulo 2^(2*DWW)
    always_comb begin
        acc_res = is_sub ? (cur - prod) : (cur + prod);
    end
`endif

    // EXECUTE decode: next bank value and next write-port contents
    always_comb begin
        wr_en_nx   = 1'b0;
        wr_data_nx = '0;
        bank_we    = 1'b0;
        bank_nx    = cur;
        case (ex_op)
            OP_MUL: begin
                bank_we = bank_ok;
                bank_nx = prod;
            end
            OP_MULACC, OP_MULSUB: begin
                bank_we = bank_ok;
                bank_nx = acc_res;
            end
            OP_CLRACC: begin
                bank_we = bank_ok;
                bank_nx = '0;
            end
            OP_ATOHI: begin
                bank_we = bank_ok;
                bank_nx = {op_a, cur[DWW-1:0]};
            end
            OP_ATOLO: begin
                bank_we = bank_ok;
                bank_nx = {cur[PW-1:DWW], op_a};
            end
            OP_MULTOW: begin
                wr_en_nx   = 1'b1;
                wr_data_nx = prod[PW-1:DWW];
            end
            OP_HITOW: begin
                wr_en_nx   = bank_ok;
                wr_data_nx = cur[PW-1:DWW];
            end
            OP_LOTOW: begin
                wr_en_nx   = bank_ok;
                wr_data_nx = cur[DWW-1:0];
            end
            OP_ATOW: begin
                wr_en_nx   = 1'b1;
                wr_data_nx = op_a;
            end
            default: ;
        endcase
    end

    // Pipeline, PC, write port and accumulator bank registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc          <= '0;
            rd_valid    <= 1'b0;
            ex_ir       <= '0;
            bus.writeEn <= 1'b0;
            bus.addrW   <= '0;
            bus.dataW   <= '0;
            for (int unsigned i = 0; i < NACC; i++) bank[i] <= '0;
        end else if (start) begin
            pc          <= '0;
            rd_valid    <= 1'b0;
            ex_ir       <= '0;
            bus.writeEn <= 1'b0;
            for (int unsigned i = 0; i < NACC; i++) bank[i] <= '0;
        end else begin
            if (running && !halt_ex) pc <= pc + 1'b1;
            rd_valid    <= running && !halt_ex;
            ex_ir       <= (rd_valid && !halt_ex) ? bus.dataI : '0;
            bus.writeEn <= wr_en_nx;
            bus.addrW   <= ex_rw;
            bus.dataW   <= wr_data_nx;
            if (bank_we) bank[ex_acc] <= bank_nx;
        end
    end
endmodule

// File: tb/tb_udsp2.sv
// Testbench for udsp2: table of short programs with their expected write
// streams, plus hand-written halt/restart and mid-program reset sequences.
module tb_udsp2;
    localparam int IAW  = 9;
    localparam int DAW  = 10;
    localparam int DWW  = 36;
    localparam int NACC = 4;
    localparam int IWW  = 6 + 2 + 3 * DAW;

    localparam int NOP = 0, MUL = 1, MULACC = 2, MULTOW = 3, ATOHI = 4, ATOLO = 5;
    localparam int HITOW = 6, LOTOW = 7, ATOW = 8, MULSUB = 9, CLRACC = 10, HALT = 11;

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic running;
    logic done;
    logic mem_init;

    int tests  = 0;
    int failed = 0;

    udsp2_if #(.IAW(IAW), .DAW(DAW), .DWW(DWW), .NACC(NACC)) bus ();

    udsp2 #(.IAW(IAW), .DAW(DAW), .DWW(DWW), .NACC(NACC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .running (running),
        .done    (done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [IWW-1:0] imem [1 << IAW];
    logic [DWW-1:0] dmem [1 << DAW];

    function automatic logic [DWW-1:0] preset(input int i);
        case (i)
            1:       preset = 36'd7;
            2:       preset = 36'd2;
            3:       preset = 36'd3;
            4:       preset = 36'hFFFFFFFFB;  // -5
            6:       preset = 36'd4;
            7:       preset = 36'h7FFFFFFFF;
            8:       preset = 36'hFFFFFFFFF;
            9:       preset = 36'd1;
            default: preset = '0;
        endcase
    endfunction

    // Synchronous memories: one-cycle read latency, read-before-write
    always @(posedge clk) begin
        bus.dataI <= imem[bus.addrI];
        bus.dataA <= dmem[bus.addrA];
        bus.dataB <= dmem[bus.addrB];
        if (mem_init) begin
            for (int i = 0; i < (1 << DAW); i++) dmem[i] <= preset(i);
        end else if (bus.writeEn) begin
            dmem[bus.addrW] <= bus.dataW;
        end
    end

    function automatic logic [IWW-1:0] ins(input int op, input int acc, input int rw,
                                           input int ra, input int rb);
        ins = {6'(op), 2'(acc), DAW'(rw), DAW'(ra), DAW'(rb)};
    endfunction

    typedef struct {
        logic [7:0][IWW-1:0]     prog;
        int                      nw;
        logic [3:0][7:0]         wc;
        logic [3:0][DAW-1:0]     wa;
        logic [3:0][DWW-1:0]     wd;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic setw(input int k, input int i, input int c, input int a,
                        input logic [DWW-1:0] d);
        vecs[k].wc[i] = 8'(c);
        vecs[k].wa[i] = DAW'(a);
        vecs[k].wd[i] = d;
        vecs[k].nw    = i + 1;
    endtask

    task automatic load_prog(input logic [7:0][IWW-1:0] p, input logic add_halt);
        for (int i = 0; i < (1 << IAW); i++) imem[i] = '0;
        for (int s = 0; s < 8; s++) imem[s] = p[s];
        if (add_halt) imem[8] = ins(HALT, 0, 0, 0, 0);
        @(negedge clk);
        mem_init = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_vec(input int k);
        int             nw;
        int             lc [4];
        logic [DAW-1:0] la [4];
        logic [DWW-1:0] ld [4];
        for (int i = 0; i < 4; i++) begin
            lc[i] = 255;
            la[i] = '0;
            ld[i] = '0;
        end
        load_prog(vecs[k].prog, 1'b1);
        pulse_start();
        nw = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.writeEn) begin
                if (nw < 4) begin
                    lc[nw] = c;
                    la[nw] = bus.addrW;
                    ld[nw] = bus.dataW;
                end
                nw++;
            end
        end
        chk($sformatf("v%0d_write_count", k), 64'(nw), 64'(vecs[k].nw));
        for (int i = 0; i < vecs[k].nw; i++)
            chk($sformatf("v%0d_write%0d_{cyc,addr,data}", k, i),
                64'({8'(lc[i]), la[i], ld[i]}),
                64'({vecs[k].wc[i], vecs[k].wa[i], vecs[k].wd[i]}));
        chk($sformatf("v%0d_halted_{running,done}", k), 64'({running, done}), 64'(2'b01));
    endtask

    initial begin
        int bad_we;
        logic [7:0][IWW-1:0] p;

        reset_n  = 1'b0;
        start    = 1'b0;
        mem_init = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vecs[k].prog = '0;
            vecs[k].nw   = 0;
            vecs[k].wc   = '0;
            vecs[k].wa   = '0;
            vecs[k].wd   = '0;
        end

        // Mul 3*-5 then read back HI and LO
        vecs[0].prog[0] = ins(MUL,   0, 0,  3, 4);
        vecs[0].prog[1] = ins(HITOW, 0, 16, 0, 0);
        vecs[0].prog[2] = ins(LOTOW, 0, 17, 0, 0);
        setw(0, 0, 4, 16, 36'hFFFFFFFFF);
        setw(0, 1, 5, 17, 36'hFFFFFFFF1);

        // Forwarded operand into MulToW, then memory-visible operand into Mul
        vecs[1].prog[0] = ins(ATOW,   0, 5,  1, 0);
        vecs[1].prog[1] = ins(MULTOW, 0, 18, 5, 2);
        vecs[1].prog[3] = ins(MUL,    0, 0,  5, 2);
        vecs[1].prog[4] = ins(LOTOW,  0, 19, 0, 0);
        vecs[1].prog[5] = ins(HITOW,  0, 20, 0, 0);
        setw(1, 0, 3, 5,  36'd7);
        setw(1, 1, 4, 18, 36'd0);
        setw(1, 2, 7, 19, 36'd14);
        setw(1, 3, 8, 20, 36'd0);

        // Three MulAcc on b1, HiToW right behind the last one, b0 untouched
        vecs[2].prog[0] = ins(MUL,    0, 0,  3, 4);
        vecs[2].prog[1] = ins(MULACC, 1, 0,  2, 6);
        vecs[2].prog[2] = ins(MULACC, 1, 0,  2, 6);
        vecs[2].prog[3] = ins(MULACC, 1, 0,  2, 6);
        vecs[2].prog[4] = ins(HITOW,  1, 16, 0, 0);
        vecs[2].prog[5] = ins(LOTOW,  1, 17, 0, 0);
        vecs[2].prog[6] = ins(LOTOW,  0, 18, 0, 0);
        setw(2, 0, 7, 16, 36'd0);
        setw(2, 1, 8, 17, 36'd24);
        setw(2, 2, 9, 18, 36'hFFFFFFFF1);

        // Bank preloaded to max positive, then MulAcc 1*1
        vecs[3].prog[0] = ins(ATOHI,  2, 0,  7, 0);
        vecs[3].prog[1] = ins(ATOLO,  2, 0,  8, 0);
        vecs[3].prog[2] = ins(MULACC, 2, 0,  9, 9);
        vecs[3].prog[3] = ins(HITOW,  2, 16, 0, 0);
        vecs[3].prog[4] = ins(LOTOW,  2, 17, 0, 0);
`ifdef UDSP2_SAT_EN
        setw(3, 0, 6, 16, 36'h7FFFFFFFF);
        setw(3, 1, 7, 17, 36'hFFFFFFFFF);
`else
        setw(3, 0, 6, 16, 36'h800000000);
        setw(3, 1, 7, 17, 36'h000000000);
`endif

        // MulSub, ClrAcc, undefined opcode, MulToW of a negative product
        vecs[4].prog[0] = ins(MUL,    3, 0,  3, 4);
        vecs[4].prog[1] = ins(MULSUB, 3, 0,  2, 6);
        vecs[4].prog[2] = ins(LOTOW,  3, 16, 0, 0);
        vecs[4].prog[3] = ins(CLRACC, 3, 0,  0, 0);
        vecs[4].prog[4] = ins(HITOW,  3, 17, 0, 0);
        vecs[4].prog[5] = ins(15,     0, 18, 1, 0);
        vecs[4].prog[6] = ins(MULTOW, 0, 19, 3, 4);
        setw(4, 0, 5, 16, 36'hFFFFFFFE9);
        setw(4, 1, 7, 17, 36'd0);
        setw(4, 2, 9, 19, 36'hFFFFFFFFF);

        // Reset state
        for (int i = 0; i < (1 << IAW); i++) imem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_addrI",   64'(bus.addrI),   64'd0);
        chk("reset_writeEn", 64'(bus.writeEn), 64'd0);
        chk("reset_addrW",   64'(bus.addrW),   64'd0);
        chk("reset_dataW",   64'(bus.dataW),   64'd0);
        chk("reset_running", 64'(running),     64'd0);
        chk("reset_done",    64'(done),        64'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_{addrI,running,done,we}",
            64'({bus.addrI, running, done, bus.writeEn}), 64'(0));

        for (int k = 0; k < 5; k++) run_vec(k);

        // Halt at address 4: squash address 5, freeze PC, then restart
        p = '0;
        p[4] = ins(HALT, 0, 0,  0, 0);
        p[5] = ins(ATOW, 0, 16, 1, 0);
        p[6] = ins(ATOW, 0, 17, 1, 0);
        load_prog(p, 1'b0);
        pulse_start();
        bad_we = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bus.writeEn) bad_we++;
            if (c == 3) chk("halt_pc_counting", 64'(bus.addrI), 64'd3);
            if (c == 6) chk("halt_ex_{running,done,pc}", 64'({running, done, bus.addrI}),
                            64'({1'b1, 1'b0, 9'd6}));
            if (c == 7) chk("halted_{running,done,pc}", 64'({running, done, bus.addrI}),
                            64'({1'b0, 1'b1, 9'd6}));
        end
        chk("halt_pc_frozen", 64'(bus.addrI), 64'd6);
        chk("halt_no_squashed_write", 64'(bad_we), 64'd0);
        pulse_start();
        @(negedge clk);
        chk("restart_{running,done,pc}", 64'({running, done, bus.addrI}),
            64'({1'b1, 1'b0, 9'd0}));
        repeat (12) @(negedge clk);

        // Reset in the middle of the MulAcc program while a write is in WRITEBACK
        load_prog(vecs[2].prog, 1'b1);
        pulse_start();
        repeat (8) @(negedge clk);
        chk("pre_reset_{we,addrW}", 64'({bus.writeEn, bus.addrW}), 64'({1'b1, 10'd16}));
        reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_writeEn", 64'(bus.writeEn), 64'd0);
        chk("midreset_{addrW,dataW}", 64'({bus.addrW, bus.dataW}), 64'd0);
        chk("midreset_{running,done,pc}", 64'({running, done, bus.addrI}), 64'd0);
        reset_n = 1'b1;
        bad_we = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.writeEn) bad_we++;
        end
        chk("post_reset_no_write", 64'(bad_we), 64'd0);
        chk("post_reset_idle_{running,pc}", 64'({running, bus.addrI}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/udsp2.md
UDSP2 -- requirements
Module: udsp2

Interface
REQ-001: Parameter IAW, default 9, instruction address width (program depth 2^IAW words).
REQ-002: Parameter DAW, default 10, data memory address width.
REQ-003: Parameter DWW, default 36, data word width (signed two's complement).
REQ-004: Parameter NACC, default 4, number of accumulator banks; ACW = max(1, clog2(NACC)).
REQ-005: Localparam IWW = 6 + ACW + 3*DAW; instruction layout, MSB first: op[6], acc[ACW], rw[DAW], ra[DAW], rb[DAW].
REQ-006: clk  input  1  sole clock; all state updates on rising edge.
REQ-007: reset_n  input  1  synchronous, active-low reset.
REQ-008: start  input  1  synchronous restart pulse.
REQ-009: addrI  output  IAW  instruction address (= PC).
REQ-010: dataI  input  IWW  instruction word; valid one cycle after addrI.
REQ-011: addrA, addrB  output  DAW each  read addresses, driven combinationally from dataI ra/rb.
REQ-012: dataA, dataB  input  DWW each  read data; valid one cycle after addrA/addrB.
REQ-013: addrW  output  DAW, dataW  output  DWW, writeEn  output  1  write port.
REQ-014: running  output  1  high while the program executes; done  output  1  high after Halt retires, until start.

Function
REQ-015: Four-stage pipeline FETCH, READ, EXECUTE, WRITEBACK; one instruction issued per cycle; no stalls.
REQ-016: Opcodes: Nop=0, Mul=1, MulAcc=2, MulToW=3, AToHi=4, AToLo=5, HiToW=6, LoToW=7, AToW=8, MulSub=9, ClrAcc=10, Halt=11; undefined opcodes behave as Nop.
REQ-017: Product = signed(A) * signed(B), 2*DWW bits; HI = upper DWW bits, LO = lower DWW bits.
REQ-018: Each accumulator bank is {HI,LO}, 2*DWW bits; acc field selects the bank; a bank index >= NACC behaves as Nop.
REQ-019: Mul loads the product; MulAcc adds the product; MulSub subtracts the product; ClrAcc zeroes the bank; AToHi/AToLo replace only HI/LO.
REQ-020: MulToW writes the product HI; HiToW/LoToW write the selected bank's HI/LO; AToW writes A.
REQ-021: Accumulator updates take effect one cycle after EXECUTE; HiToW immediately after MulAcc on the same bank SHALL observe the updated value (accumulator bypass).
REQ-022: Operand forwarding compares the EXECUTE instruction's own ra/rb against the WRITEBACK rw while writeEn=1; on a match, wbData replaces the memory data.
REQ-023: A write issued in WRITEBACK is visible to a read issued in FETCH in the same cycle only through memory semantics; the core adds no extra hazard logic.
REQ-024: PC increments by 1 per cycle while running=1 and wraps from 2^IAW-1 to 0.
REQ-025: start=1: PC<=0, all pipeline instruction registers <= Nop, writeEn<=0, all banks <=0, running<=1, done<=0.
REQ-026: Halt in EXECUTE: running<=0, done<=1, the READ-stage instruction is squashed to Nop, PC holds; the WRITEBACK-stage instruction completes.
REQ-027: While running=0, fetched words are replaced by Nop; PC and banks hold; writeEn=0 after drain.
REQ-028: start and Halt in the same cycle: start wins.

Reset
REQ-029: reset_n=0 at a clock edge: PC=0, pipeline = Nop, banks = 0, writeEn=0, addrW=0, dataW=0, running=0, done=0.
REQ-030: reset_n has priority over start; reset mid-program abandons all in-flight writes with no spurious writeEn.
REQ-031: After reset the core idles until the first start pulse.

Configuration
REQ-032: Macro UDSP2_SAT_EN defined: MulAcc/MulSub results saturate to the signed 2*DWW limits.
REQ-033: UDSP2_SAT_EN undefined: MulAcc/MulSub wrap modulo 2^(2*DWW); no saturation logic is synthesised.

Verification
REQ-034: Reset, start; program Mul b0 (A=3, B=-5), HiToW, LoToW -> HI=all-ones, LO=-15 written at expected cycles.
REQ-035: AToW m[5]<=m[1]=7, followed immediately by MulToW using ra=5, B=2 -> forwarded operand gives writeback 0 HI, product 14.
REQ-036: MulAcc on b1 three times (A=2, B=4), then HiToW/LoToW on b1 -> LO=24; b0 unchanged.
REQ-037: With UDSP2_SAT_EN, bank preloaded to max positive, MulAcc 1*1 -> bank = 0x7FF..F; without the macro -> wraps to min negative.
REQ-038: Halt at address 4 -> running falls, done rises, PC frozen, no writeEn from the squashed word at address 5; start mid-halt restarts at PC=0.
REQ-039: reset_n low for one cycle during MulAcc sequence -> all outputs return to reset values next cycle; running=0.
